// File: rtl/pxs_pkg.sv
// pxs_pkg: definitions shared by the pixel-stream (pxs) overlay blocks.
//   - bit positions of the fields in the 23-bit VGA stream word
//   - stream widths with and without the 3-bit RGB extension
//   - 3-bit colour constants used by the painters
//   - state encoding of the per-frame scheduler FSM
package pxs_pkg;

    localparam int unsigned VGA_W     = 23;
    localparam int unsigned VGA_RGB_W = 26;

    localparam int unsigned AV_BIT = 0;
    localparam int unsigned VS_BIT = 1;
    localparam int unsigned HS_BIT = 2;
    localparam int unsigned Y_LSB  = 3;
    localparam int unsigned Y_MSB  = 12;
    localparam int unsigned X_LSB  = 13;
    localparam int unsigned X_MSB  = 22;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned DIV_W   = 8;

    localparam logic [2:0] RGB_BLACK = 3'b000;
    localparam logic [2:0] RGB_BLUE  = 3'b001;
    localparam logic [2:0] RGB_GREEN = 3'b010;
    localparam logic [2:0] RGB_RED   = 3'b100;
    localparam logic [2:0] RGB_WHITE = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_MOVE       = 2'd2
    } sched_state_e;

endpackage

// File: rtl/pxs_line_scheduler_if.sv
// pxs_line_scheduler_if: signal bundle between the line scheduler and its
// environment.
//   VGAStr_i   : 23-bit VGA stream (AV, VSync, HSync, YCoord, XCoord)
//   run        : motion enable level
//   step_i     : pixels per move (0..15)
//   line_y     : current line row
//   dir_o      : 0 = moving down, 1 = moving up
//   frame_tick : one-cycle pulse per frame start
//   busy       : scheduler FSM not idle
// master = stream/control source, slave = scheduler.
interface pxs_line_scheduler_if;
    import pxs_pkg::*;

    logic [VGA_W-1:0]   VGAStr_i;
    logic               run;
    logic [3:0]         step_i;
    logic [COORD_W-1:0] line_y;
    logic               dir_o;
    logic               frame_tick;
    logic               busy;

    modport master (
        output VGAStr_i, run, step_i,
        input  line_y, dir_o, frame_tick, busy
    );

    modport slave (
        input  VGAStr_i, run, step_i,
        output line_y, dir_o, frame_tick, busy
    );

endinterface

// File: rtl/pxs_vsync_edge.sv
// pxs_vsync_edge: registers VSync and emits a one-cycle tick on each
// inactive->active transition (polarity set by VS_POL).
//   clk     : pixel clock
//   rst     : asynchronous active-high reset
//   vsync_i : raw VSync bit from the stream
//   tick_o  : registered frame-start pulse, high the cycle after the
//             sample that shows the transition
module pxs_vsync_edge #(
    parameter bit VS_POL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic vsync_i,
    output logic tick_o
);

    logic vs_q, vs_d;
    logic tick_q, tick_d;

    always_comb begin
        vs_d   = vsync_i;
        tick_d = (vsync_i == VS_POL) && (vs_q != VS_POL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q   <= ~VS_POL;
            tick_q <= 1'b0;
        end else begin
            vs_q   <= vs_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/pxs_line_scheduler.sv
// pxs_line_scheduler: per-frame motion controller for the overlay line.
// Every FRAME_DIV frame starts (while run is high) the line row moves by
// step_i pixels, bouncing between Y_MIN and Y_MAX. line_y feeds the
// downstream constant-colour painter; no pixels are produced here.
//   px_clk : pixel clock
//   reset  : asynchronous active-high reset
//   bus    : slave side of pxs_line_scheduler_if (stream in, run, step_i,
//            line_y, dir_o, frame_tick, busy)
module pxs_line_scheduler
    import pxs_pkg::*;
#(
    parameter int unsigned Y_MIN     = 0,
    parameter int unsigned Y_MAX     = 479,
    parameter int unsigned Y_INIT    = 245,
    parameter int unsigned FRAME_DIV = 1,
    parameter bit          VS_POL    = 1'b0
) (
    input  logic                 px_clk,
    input  logic                 reset,
    pxs_line_scheduler_if.slave  bus
);

    localparam logic [10:0]        Y_MIN_L  = 11'(Y_MIN);
    localparam logic [10:0]        Y_MAX_L  = 11'(Y_MAX);
    localparam logic [COORD_W-1:0] Y_INIT_L = COORD_W'(Y_INIT);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(FRAME_DIV - 1);

    sched_state_e       state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [COORD_W-1:0] line_y_q, line_y_d;
    logic               dir_q, dir_d;

    logic               frame_tick;
    logic [10:0]        sum;
    logic [COORD_W-1:0] diff;
    logic [10:0]        up_limit;
    logic [COORD_W-1:0] move_y;
    logic               move_dir;
    logic               stream_unused;

    // Only VSync matters here; the remaining stream fields are sunk.
    always_comb stream_unused = ^{bus.VGAStr_i[VGA_W-1:VS_BIT+1], bus.VGAStr_i[AV_BIT]};

    pxs_vsync_edge #(
        .VS_POL (VS_POL)
    ) u_vsync_edge (
        .clk     (px_clk),
        .rst     (reset),
        .vsync_i (bus.VGAStr_i[VS_BIT]),
        .tick_o  (frame_tick)
    );

    // Bounce datapath. A zero step never bounces, so the limits are
    // left untouched when step_i is 0. The up branch only subtracts when
    // line_y > Y_MIN + s, so the 10-bit difference cannot wrap.
    always_comb begin
        sum      = {1'b0, line_y_q} + {7'b0, bus.step_i};
        up_limit = Y_MIN_L + {7'b0, bus.step_i};
        diff     = line_y_q - {6'b0, bus.step_i};
        move_y   = line_y_q;
        move_dir = dir_q;
        if (bus.step_i != 4'd0) begin
            if (!dir_q) begin
                if (sum >= Y_MAX_L) begin
                    move_y   = Y_MAX_L[COORD_W-1:0];
                    move_dir = 1'b1;
                end else begin
                    move_y   = sum[COORD_W-1:0];
                end
            end else begin
                if ({1'b0, line_y_q} <= up_limit) begin
                    move_y   = Y_MIN_L[COORD_W-1:0];
                    move_dir = 1'b0;
                end else begin
                    move_y   = diff;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        line_y_d = line_y_q;
        dir_d    = dir_q;
        case (state_q)
            ST_IDLE: begin
                div_d = '0;
                if (bus.run) state_d = ST_WAIT_FRAME;
            end
            ST_WAIT_FRAME: begin
                // Dropping run wins over a tick arriving in the same cycle.
                if (!bus.run) begin
                    state_d = ST_IDLE;
                    div_d   = '0;
                end else if (frame_tick) begin
                    if (div_q == DIV_LAST) begin
                        div_d   = '0;
                        state_d = ST_MOVE;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
            end
            ST_MOVE: begin
                line_y_d = move_y;
                dir_d    = move_dir;
                state_d  = bus.run ? ST_WAIT_FRAME : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                div_d   = '0;
            end
        endcase
    end

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            div_q    <= '0;
            line_y_q <= Y_INIT_L;
            dir_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            line_y_q <= line_y_d;
            dir_q    <= dir_d;
        end
    end

    assign bus.line_y     = line_y_q;
    assign bus.dir_o      = dir_q;
    assign bus.frame_tick = frame_tick;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pxs_line_scheduler.sv
module tb_pxs_line_scheduler;

    localparam int TB_Y_MIN  = 0;
    localparam int TB_Y_MAX  = 479;
    localparam int TB_Y_INIT = 245;
    localparam int TB_DIV_B  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pxs_line_scheduler_if if_a ();
    pxs_line_scheduler_if if_b ();

    pxs_line_scheduler #(.FRAME_DIV(1)) dut_a (
        .px_clk (clk),
        .reset  (rst),
        .bus    (if_a)
    );

    pxs_line_scheduler #(.FRAME_DIV(TB_DIV_B)) dut_b (
        .px_clk (clk),
        .reset  (rst),
        .bus    (if_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: position, direction, ticks since enable.
    int ma_y, ma_dir;
    int mb_y, mb_dir, mb_cnt;
    int run_a, run_b, step_a, step_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_step(inout int y, inout int dir, input int s);
        if (s == 0) return;
        if (dir == 0) begin
            y = (y + s > TB_Y_MAX) ? TB_Y_MAX : y + s;
            if (y == TB_Y_MAX) dir = 1;
        end else begin
            y = (y - s < TB_Y_MIN) ? TB_Y_MIN : y - s;
            if (y == TB_Y_MIN) dir = 0;
        end
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // VSync is active-low (VS_POL = 0); other fields are random filler.
    task automatic drive_stream(input bit vs_active);
        logic [22:0] st;
        st    = 23'($urandom);
        st[1] = vs_active ? 1'b0 : 1'b1;
        if_a.VGAStr_i = st;
        if_b.VGAStr_i = st;
    endtask

    task automatic apply_ctrl();
        if_a.run    = run_a[0];
        if_b.run    = run_b[0];
        if_a.step_i = 4'(step_a);
        if_b.step_i = 4'(step_b);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            drive_stream(1'b0);
            @(negedge clk);
        end
    endtask

    task automatic set_run_a(input int v);
        run_a = v;
        apply_ctrl();
        idle_cycles(2);
    endtask

    task automatic set_run_b(input int v);
        run_b = v;
        if (v == 0) mb_cnt = 0;
        apply_ctrl();
        idle_cycles(2);
    endtask

    // One frame: VSync goes active right after a falling edge; the update
    // must be invisible two edges later and visible on the third.
    task automatic frame();
        apply_ctrl();
        drive_stream(1'b1);
        @(negedge clk);
        check("tick_a", if_a.frame_tick, 1);
        check("tick_b", if_b.frame_tick, 1);
        drive_stream(1'b1);
        @(negedge clk);
        check("hold_y_a", if_a.line_y, ma_y);
        check("busy_a", if_a.busy, run_a);
        check("tick_a_off", if_a.frame_tick, 0);
        drive_stream(1'b1);
        @(negedge clk);
        if (run_a != 0) model_step(ma_y, ma_dir, step_a);
        if (run_b != 0) begin
            mb_cnt++;
            if (mb_cnt == TB_DIV_B) begin
                mb_cnt = 0;
                model_step(mb_y, mb_dir, step_b);
            end
        end
        check("y_a", if_a.line_y, ma_y);
        check("dir_a", if_a.dir_o, ma_dir);
        check("y_b", if_b.line_y, mb_y);
        check("dir_b", if_b.dir_o, mb_dir);
        drive_stream(1'b1);
        @(negedge clk);
        idle_cycles(6);
    endtask

    task automatic model_reset();
        ma_y = TB_Y_INIT; ma_dir = 0;
        mb_y = TB_Y_INIT; mb_dir = 0; mb_cnt = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_y_a"}, if_a.line_y, TB_Y_INIT);
        check({tag, "_dir_a"}, if_a.dir_o, 0);
        check({tag, "_busy_a"}, if_a.busy, 0);
        check({tag, "_tick_a"}, if_a.frame_tick, 0);
        check({tag, "_y_b"}, if_b.line_y, TB_Y_INIT);
        check({tag, "_busy_b"}, if_b.busy, 0);
    endtask

    initial begin
        int y0;
        rst = 1'b1;
        run_a = 0; run_b = 0; step_a = 0; step_b = 0;
        apply_ctrl();
        model_reset();
        drive_stream(1'b1);
        repeat (2) @(negedge clk);
        check_reset_values("reset");

        drive_stream(1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(3);
        check_reset_values("post_reset");

        // Basic move: step 5 per frame.
        step_a = 5;
        step_b = int'($urandom_range(0, 15));
        set_run_a(1);
        set_run_b(1);
        frame(); check("basic_1", if_a.line_y, 250);
        frame(); check("basic_2", if_a.line_y, 255);
        frame(); check("basic_3", if_a.line_y, 260);

        // Walk down to 476, then bounce off the bottom.
        while (ma_y != 476) begin
            step_a = imin(15, 476 - ma_y);
            step_b = int'($urandom_range(0, 15));
            frame();
        end
        step_a = 5; frame();
        check("bot_bounce_y", if_a.line_y, 479);
        check("bot_bounce_dir", if_a.dir_o, 1);
        step_a = 0; frame();
        check("step0_max_y", if_a.line_y, 479);
        check("step0_max_dir", if_a.dir_o, 1);
        step_a = 5; frame();
        check("after_bot_y", if_a.line_y, 474);

        // Walk up to 3, then bounce off the top.
        while (ma_y != 3) begin
            step_a = imin(15, ma_y - 3);
            step_b = int'($urandom_range(0, 15));
            frame();
        end
        step_a = 5; frame();
        check("top_bounce_y", if_a.line_y, 0);
        check("top_bounce_dir", if_a.dir_o, 0);
        frame();
        check("after_top_y", if_a.line_y, 5);

        // Divider: two ticks, drop run, then four fresh ticks per move.
        step_b = 7;
        set_run_b(0);
        set_run_b(1);
        frame(); frame();
        set_run_b(0);
        set_run_b(1);
        y0 = mb_y;
        frame(); check("div_hold_1", if_b.line_y, y0);
        frame(); check("div_hold_2", if_b.line_y, y0);
        frame(); check("div_hold_3", if_b.line_y, y0);
        frame();
        check("div_moved", (if_b.line_y != 10'(y0)) ? 1 : 0, 1);

        // Random steps and run toggling against the model.
        for (int i = 0; i < 40; i++) begin
            step_a = int'($urandom_range(0, 15));
            step_b = int'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) set_run_a(1 - run_a);
            if ($urandom_range(0, 5) == 0) set_run_b(1 - run_b);
            frame();
        end

        // Reset while A is in MOVE.
        set_run_a(1);
        set_run_b(1);
        step_a = 9;
        apply_ctrl();
        drive_stream(1'b1);
        @(negedge clk);
        drive_stream(1'b1);
        @(negedge clk);
        check("move_busy", if_a.busy, 1);
        rst = 1'b1;
        #1;
        check_reset_values("mid_reset");
        drive_stream(1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle_cycles(3);
        frame();
        frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
